// File: rtl/prefetch_pkg.sv
// Shared types and push-limit derivation for the flow prefetch buffer.
// PREFETCH_REINSERT_RESERVE_EN keeps one slot per flow free for reinserts.
package prefetch_pkg;

  localparam int FLOW_ID_W = 8;
  localparam int CNT_MAX_W = 7;

  typedef logic [FLOW_ID_W-1:0] flow_id_t;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

  typedef struct packed {
    logic push;
    logic reinsert;
    logic pop;
  } flow_req_t;

  function automatic int push_limit(input int depth);
`ifdef PREFETCH_REINSERT_RESERVE_EN
    return depth - 1;
`else
    return depth;
`endif
  endfunction

  function automatic logic id_hit(input flow_id_t id, input int f);
    return id == flow_id_t'(f);
  endfunction

endpackage

// File: rtl/flow_deque.sv
// One flow queue: circular deque with tail push, head reinsert and head pop.
// Push limit comes from prefetch_pkg (PREFETCH_REINSERT_RESERVE_EN aware).
module flow_deque
  import prefetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  flow_req_t             req,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [DATA_WIDTH-1:0] reinsert_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  push_ok,
  output logic                  reinsert_drop
);

  localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PUSH_LIMIT = push_limit(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] head_dec;
  logic [PW-1:0] head_inc;
  logic [PW-1:0] tail;
  cnt_t cnt_ext;
  cnt_t sum;
  cnt_t cnt_nxt;
  logic empty;
  logic pop_ok;
  logic pop_only;
  logic overwrite;
  logic reins_ok;
  logic reins_drop;
  logic push_acc;

  always_comb begin
    cnt_ext    = cnt_t'(count);
    empty      = (count == '0);
    pop_ok     = req.pop && !empty;
    overwrite  = pop_ok && req.reinsert;
    pop_only   = pop_ok && !req.reinsert;
    reins_ok   = req.reinsert && !pop_ok
              && (cnt_ext < cnt_t'(DEPTH));
    reins_drop = req.reinsert && !pop_ok && !reins_ok;
    // a same-cycle pop does not free a slot for push
    push_ok    = (cnt_ext + cnt_t'(reins_ok))
               < cnt_t'(PUSH_LIMIT);
    push_acc   = req.push && push_ok;
    head_dec   = (head == '0) ? PW'(DEPTH - 1)
                              : head - PW'(1);
    head_inc   = (head == PW'(DEPTH - 1)) ? '0
                                          : head + PW'(1);
    sum        = cnt_t'(head) + cnt_ext;
    tail       = (sum >= cnt_t'(DEPTH))
               ? PW'(sum - cnt_t'(DEPTH)) : PW'(sum);
    cnt_nxt    = cnt_ext + cnt_t'(reins_ok)
               + cnt_t'(push_acc) - cnt_t'(pop_only);
    head_data  = empty ? '0 : mem[head];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head          <= '0;
      count         <= '0;
      reinsert_drop <= 1'b0;
    end else begin
      reinsert_drop <= reins_drop;
      count         <= CNT_WIDTH'(cnt_nxt);
      unique case (1'b1)
        reins_ok: head <= head_dec;
        pop_only: head <= head_inc;
        default:  head <= head;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (overwrite) mem[head] <= reinsert_data;
    if (reins_ok)  mem[head_dec] <= reinsert_data;
    if (push_acc)  mem[tail] <= push_data;
  end

endmodule

// File: rtl/flow_prefetch_buffer.sv
// Per-flow prefetch deques with tail push, head reinsert and indexed pop.
// Define PREFETCH_REINSERT_RESERVE_EN to reserve one slot per flow.
module flow_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter  int NUM_FLOWS  = 16,
  parameter  int DEPTH      = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int IDX_WIDTH  = $clog2(NUM_FLOWS + 1),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__push_valid,
  input  logic [IDX_WIDTH-1:0]  i__push_flow_id,
  input  logic [DATA_WIDTH-1:0] i__push_data,
  output logic                  o__push_flow_not_full,
  input  logic                  i__reinsert_valid,
  input  logic [IDX_WIDTH-1:0]  i__reinsert_flow_id,
  input  logic [DATA_WIDTH-1:0] i__reinsert_data,
  output logic                  o__reinsert_drop,
  input  logic                  i__pop,
  input  logic [IDX_WIDTH-1:0]  i__pop_flow_id,
  output logic                  o__pop_valid,
  output logic [DATA_WIDTH-1:0] o__pop_data,
  output logic [NUM_FLOWS-1:0]  o__flow_nonempty,
  output logic [CNT_WIDTH-1:0]  o__pop_flow_count
);

  logic [CNT_WIDTH-1:0]  cnt  [NUM_FLOWS];
  logic [DATA_WIDTH-1:0] head [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]  push_ok;
  logic [NUM_FLOWS-1:0]  drop;

  for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_flow
    flow_req_t req;

    always_comb begin
      req.push     = i__push_valid
                  && id_hit(flow_id_t'(i__push_flow_id), f);
      req.reinsert = i__reinsert_valid
                  && id_hit(flow_id_t'(i__reinsert_flow_id), f);
      req.pop      = i__pop
                  && id_hit(flow_id_t'(i__pop_flow_id), f);
    end

    flow_deque #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_deque (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .push_data     (i__push_data),
      .reinsert_data (i__reinsert_data),
      .head_data     (head[f]),
      .count         (cnt[f]),
      .push_ok       (push_ok[f]),
      .reinsert_drop (drop[f])
    );

    assign o__flow_nonempty[f] = (cnt[f] != '0);
  end

  // out-of-range ids match no flow, so outputs stay 0
  always_comb begin
    o__pop_valid          = 1'b0;
    o__pop_data           = '0;
    o__pop_flow_count     = '0;
    o__push_flow_not_full = 1'b0;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      if (i__pop_flow_id == IDX_WIDTH'(f)) begin
        o__pop_valid      = (cnt[f] != '0);
        o__pop_data       = head[f];
        o__pop_flow_count = cnt[f];
      end
      if (i__push_flow_id == IDX_WIDTH'(f))
        o__push_flow_not_full = push_ok[f];
    end
    o__reinsert_drop = |drop;
  end

endmodule

// File: tb/tb_flow_prefetch_buffer.sv
// Directed self-checking bench for flow_prefetch_buffer.
// Exercises both builds of PREFETCH_REINSERT_RESERVE_EN.
module tb_flow_prefetch_buffer;

  localparam int NF = 16;
  localparam int DP = 4;
  localparam int DW = 8;
  localparam int IW = 5;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          i__push_valid;
  logic [IW-1:0] i__push_flow_id;
  logic [DW-1:0] i__push_data;
  logic          o__push_flow_not_full;
  logic          i__reinsert_valid;
  logic [IW-1:0] i__reinsert_flow_id;
  logic [DW-1:0] i__reinsert_data;
  logic          o__reinsert_drop;
  logic          i__pop;
  logic [IW-1:0] i__pop_flow_id;
  logic          o__pop_valid;
  logic [DW-1:0] o__pop_data;
  logic [NF-1:0] o__flow_nonempty;
  logic [CW-1:0] o__pop_flow_count;

  int n_checks;
  int n_errors;

  flow_prefetch_buffer #(
    .NUM_FLOWS  (NF),
    .DEPTH      (DP),
    .DATA_WIDTH (DW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i__push_valid         (i__push_valid),
    .i__push_flow_id       (i__push_flow_id),
    .i__push_data          (i__push_data),
    .o__push_flow_not_full (o__push_flow_not_full),
    .i__reinsert_valid     (i__reinsert_valid),
    .i__reinsert_flow_id   (i__reinsert_flow_id),
    .i__reinsert_data      (i__reinsert_data),
    .o__reinsert_drop      (o__reinsert_drop),
    .i__pop                (i__pop),
    .i__pop_flow_id        (i__pop_flow_id),
    .o__pop_valid          (o__pop_valid),
    .o__pop_data           (o__pop_data),
    .o__flow_nonempty      (o__flow_nonempty),
    .o__pop_flow_count     (o__pop_flow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i__push_valid       = 1'b0;
    i__push_flow_id     = '0;
    i__push_data        = '0;
    i__reinsert_valid   = 1'b0;
    i__reinsert_flow_id = '0;
    i__reinsert_data    = '0;
    i__pop              = 1'b0;
    #1;
  endtask

  task automatic push(input logic [IW-1:0] f,
                      input logic [DW-1:0] d);
    i__push_valid   = 1'b1;
    i__push_flow_id = f;
    i__push_data    = d;
    cyc();
    idle();
  endtask

  task automatic sel(input logic [IW-1:0] f);
    i__pop_flow_id = f;
    #1;
  endtask

  task automatic pop_one(input logic [IW-1:0] f);
    i__pop_flow_id = f;
    i__pop         = 1'b1;
    cyc();
    idle();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    clk            = 1'b0;
    reset          = 1'b0;
    i__pop_flow_id = 5'd3;
    idle();
    i__push_flow_id = 5'd3;
    #1;
    check("rst_valid", 32'(o__pop_valid), 0);
    check("rst_nonempty", 32'(o__flow_nonempty), 0);
    check("rst_count", 32'(o__pop_flow_count), 0);
    check("rst_data", 32'(o__pop_data), 0);
    check("rst_drop", 32'(o__reinsert_drop), 0);
    check("rst_notfull", 32'(o__push_flow_not_full), 1);
    i__push_flow_id = 5'd16;
    #1;
    check("rst_notfull_bad",
          32'(o__push_flow_not_full), 0);
    #10 reset = 1'b1;

    // basic push / fall-through pop on flow 3
    push(5'd3, 8'h11);
    push(5'd3, 8'h22);
    sel(5'd3);
    check("b_count", 32'(o__pop_flow_count), 2);
    check("b_data", 32'(o__pop_data), 32'h11);
    check("b_nonempty", 32'(o__flow_nonempty), 32'h8);
    pop_one(5'd3);
    check("b_pop_data", 32'(o__pop_data), 32'h22);
    check("b_pop_count", 32'(o__pop_flow_count), 1);
    pop_one(5'd3);
    check("b_empty_count", 32'(o__pop_flow_count), 0);
    check("b_empty_valid", 32'(o__pop_valid), 0);
    pop_one(5'd3);
    check("b_underflow", 32'(o__pop_flow_count), 0);
    check("b_under_ne", 32'(o__flow_nonempty), 0);

    // same-flow pop + reinsert overwrites head
    push(5'd5, 8'h10);
    push(5'd5, 8'h20);
    i__pop_flow_id      = 5'd5;
    i__pop              = 1'b1;
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd5;
    i__reinsert_data    = 8'h7f;
    cyc();
    idle();
    check("ow_data", 32'(o__pop_data), 32'h7f);
    check("ow_count", 32'(o__pop_flow_count), 2);
    check("ow_drop", 32'(o__reinsert_drop), 0);
    pop_one(5'd5);
    check("ow_next", 32'(o__pop_data), 32'h20);
    check("ow_next_cnt", 32'(o__pop_flow_count), 1);

    // three flows in one cycle
    push(5'd3, 8'h33);
    i__push_valid       = 1'b1;
    i__push_flow_id     = 5'd1;
    i__push_data        = 8'h01;
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd2;
    i__reinsert_data    = 8'h02;
    i__pop              = 1'b1;
    i__pop_flow_id      = 5'd3;
    cyc();
    idle();
    sel(5'd1);
    check("tri_c1", 32'(o__pop_flow_count), 1);
    check("tri_d1", 32'(o__pop_data), 32'h01);
    sel(5'd2);
    check("tri_c2", 32'(o__pop_flow_count), 1);
    check("tri_d2", 32'(o__pop_data), 32'h02);
    sel(5'd3);
    check("tri_c3", 32'(o__pop_flow_count), 0);

    // flow id 16 is out of range
    i__push_valid       = 1'b1;
    i__push_flow_id     = 5'd16;
    i__push_data        = 8'h99;
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd16;
    i__reinsert_data    = 8'h66;
    i__pop              = 1'b1;
    i__pop_flow_id      = 5'd16;
    #1;
    check("bad_notfull", 32'(o__push_flow_not_full), 0);
    check("bad_valid", 32'(o__pop_valid), 0);
    check("bad_data", 32'(o__pop_data), 0);
    cyc();
    idle();
    check("bad_nonempty", 32'(o__flow_nonempty), 32'h26);
    check("bad_drop", 32'(o__reinsert_drop), 0);

    // push + reinsert same flow same cycle
    i__push_valid       = 1'b1;
    i__push_flow_id     = 5'd2;
    i__push_data        = 8'hb2;
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd2;
    i__reinsert_data    = 8'ha2;
    #1;
    check("pr_notfull", 32'(o__push_flow_not_full), 1);
    cyc();
    idle();
    sel(5'd2);
    check("pr_count", 32'(o__pop_flow_count), 3);
    check("pr_head", 32'(o__pop_data), 32'ha2);
    pop_one(5'd2);
    check("pr_mid", 32'(o__pop_data), 32'h02);
    pop_one(5'd2);
    check("pr_tail", 32'(o__pop_data), 32'hb2);
    check("pr_tail_cnt", 32'(o__pop_flow_count), 1);
    pop_one(5'd2);
    check("pr_drain", 32'(o__pop_flow_count), 0);

`ifdef PREFETCH_REINSERT_RESERVE_EN
    push(5'd0, 8'hc0);
    push(5'd0, 8'hc1);
    push(5'd0, 8'hc2);
    sel(5'd0);
    check("rv_notfull", 32'(o__push_flow_not_full), 0);
    check("rv_count3", 32'(o__pop_flow_count), 3);
    pop_one(5'd0);
    check("rv_pop_cnt", 32'(o__pop_flow_count), 2);
    check("rv_pop_dat", 32'(o__pop_data), 32'hc1);
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd0;
    i__reinsert_data    = 8'haa;
    cyc();
    idle();
    check("rv_ri_cnt", 32'(o__pop_flow_count), 3);
    check("rv_ri_head", 32'(o__pop_data), 32'haa);
    check("rv_ri_drop", 32'(o__reinsert_drop), 0);
    check("rv_ri_nf", 32'(o__push_flow_not_full), 0);
    pop_one(5'd0);
    check("rv_d1", 32'(o__pop_data), 32'hc1);
    pop_one(5'd0);
    check("rv_d2", 32'(o__pop_data), 32'hc2);
    pop_one(5'd0);
    check("rv_d3", 32'(o__pop_flow_count), 0);
`else
    push(5'd0, 8'hc0);
    push(5'd0, 8'hc1);
    push(5'd0, 8'hc2);
    sel(5'd0);
    check("nf_three", 32'(o__push_flow_not_full), 1);
    push(5'd0, 8'hc3);
    check("nf_full", 32'(o__push_flow_not_full), 0);
    i__reinsert_valid   = 1'b1;
    i__reinsert_flow_id = 5'd0;
    i__reinsert_data    = 8'h55;
    cyc();
    idle();
    check("dr_pulse", 32'(o__reinsert_drop), 1);
    check("dr_count", 32'(o__pop_flow_count), 4);
    check("dr_head", 32'(o__pop_data), 32'hc0);
    cyc();
    check("dr_clear", 32'(o__reinsert_drop), 0);
    pop_one(5'd0);
    check("wr_pop", 32'(o__pop_data), 32'hc1);
    check("wr_cnt", 32'(o__pop_flow_count), 3);
    push(5'd0, 8'hc4);
    check("wr_full", 32'(o__pop_flow_count), 4);
    pop_one(5'd0);
    check("wr_d2", 32'(o__pop_data), 32'hc2);
    pop_one(5'd0);
    check("wr_d3", 32'(o__pop_data), 32'hc3);
    pop_one(5'd0);
    check("wr_d4", 32'(o__pop_data), 32'hc4);
    pop_one(5'd0);
    check("wr_empty", 32'(o__pop_flow_count), 0);
`endif

    // asynchronous reset with several flows busy
    push(5'd7, 8'h70);
    push(5'd8, 8'h80);
    push(5'd9, 8'h90);
    check("ar_before", 32'(o__flow_nonempty), 32'h3a2);
    #2 reset = 1'b0;
    #1;
    check("ar_nonempty", 32'(o__flow_nonempty), 0);
    sel(5'd7);
    check("ar_count", 32'(o__pop_flow_count), 0);
    check("ar_valid", 32'(o__pop_valid), 0);
    check("ar_data", 32'(o__pop_data), 0);
    check("ar_drop", 32'(o__reinsert_drop), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(5'd7, 8'h77);
    check("ar_rel_cnt", 32'(o__pop_flow_count), 1);
    check("ar_rel_dat", 32'(o__pop_data), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flow_prefetch_buffer.md
FLOW_PREFETCH_BUFFER -- requirements
Module: flow_prefetch_buffer

Interface
REQ-001 SHALL have parameter NUM_FLOWS, default 16, number of per-flow queues.
REQ-002 SHALL have parameter DEPTH, default 4, entries per flow queue, legal range 2..64.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, entry width (priority value).
REQ-004 SHALL derive IDX_WIDTH = clog2(NUM_FLOWS+1) and CNT_WIDTH = clog2(DEPTH+1).
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 i__push_valid  input  1  push request at tail.
REQ-009 i__push_flow_id  input  IDX_WIDTH  push target flow.
REQ-010 i__push_data  input  DATA_WIDTH  push entry.
REQ-011 o__push_flow_not_full  output  1  push to i__push_flow_id accepted this cycle.
REQ-012 i__reinsert_valid  input  1  return entry to head of a flow.
REQ-013 i__reinsert_flow_id  input  IDX_WIDTH  reinsert target flow (independent of pop id).
REQ-014 i__reinsert_data  input  DATA_WIDTH  reinsert entry.
REQ-015 o__reinsert_drop  output  1  registered pulse: previous-cycle reinsert discarded.
REQ-016 i__pop  input  1  remove head of i__pop_flow_id.
REQ-017 i__pop_flow_id  input  IDX_WIDTH  flow to read/pop.
REQ-018 o__pop_valid  output  1  selected flow non-empty.
REQ-019 o__pop_data  output  DATA_WIDTH  head entry of selected flow (fall-through).
REQ-020 o__flow_nonempty  output  NUM_FLOWS  per-flow count != 0 bitmap.
REQ-021 o__pop_flow_count  output  CNT_WIDTH  occupancy of i__pop_flow_id.

Function
REQ-022 Each flow SHALL be a circular deque: head pointer, count; push writes tail, reinsert writes slot head-1 and moves head back, pop advances head.
REQ-023 Flow id >= NUM_FLOWS SHALL be ignored for push/reinsert/pop; selected outputs read 0.
REQ-024 o__pop_valid/o__pop_data/o__pop_flow_count SHALL be combinational from registered state; zero-latency read, pushed data visible the cycle after push.
REQ-025 Pop on empty flow SHALL be ignored (no underflow, count stays 0).
REQ-026 Pop and reinsert on same flow, same cycle, non-empty: head entry overwritten with reinsert data, head and count unchanged.
REQ-027 Reinsert without same-flow pop SHALL be accepted if count < DEPTH, else dropped and o__reinsert_drop=1 next cycle.
REQ-028 o__push_flow_not_full SHALL equal (count + accepted same-flow reinsert without pop) < PUSH_LIMIT; same-cycle pop grants no push credit.
REQ-029 Push, pop, reinsert on three different flows SHALL all complete in one cycle.
REQ-030 Push and reinsert to same flow same cycle, both accepted: reinsert becomes head, push becomes tail, count += 2 (minus 1 if popped).
REQ-031 Pointers SHALL wrap modulo DEPTH; non-power-of-two DEPTH supported.

Reset
REQ-032 Reset asserted SHALL asynchronously clear all counts and head pointers; entry storage not cleared.
REQ-033 During/after reset: o__pop_valid=0, o__flow_nonempty=0, o__pop_flow_count=0, o__reinsert_drop=0, o__pop_data=0; o__push_flow_not_full=1 for legal ids.
REQ-034 Reset mid-operation SHALL discard all queued entries; no request in the deassertion cycle is lost once reset is sampled high.

Configuration
REQ-035 Macro PREFETCH_REINSERT_RESERVE_EN defined: PUSH_LIMIT = DEPTH-1, one slot per flow reserved for reinsert, so a reinsert following a pop never drops.
REQ-036 Macro undefined: PUSH_LIMIT = DEPTH; reinsert may drop per REQ-027.

Structure
REQ-037 Shared package prefetch_pkg SHALL hold flow-id and count typedefs and the PUSH_LIMIT derivation function.
REQ-038 Per-flow storage and pointer logic SHALL be sub-module flow_deque, instantiated NUM_FLOWS times by generate.

Verification
REQ-039 Reset, push 0x11,0x22 to flow 3 -> count 2, pop_data 0x11; pop -> pop_data 0x22 next cycle.
REQ-040 DEPTH=4, no macro: push 4 to flow 0 -> not_full=0; reinsert 0x55 flow 0 -> drop pulse, count 4.
REQ-041 Macro on, DEPTH=4: 3 pushes -> not_full=0; pop then reinsert 0xAA -> count 3, head 0xAA, no drop.
REQ-042 Same-cycle pop+reinsert 0x7F flow 5 holding {0x10,0x20} -> head 0x7F, count 2.
REQ-043 Push flow 1, reinsert flow 2, pop flow 3 same cycle -> all counts update; flow id 16 with NUM_FLOWS=16 ignored.
REQ-044 Assert reset with 3 flows non-empty -> o__flow_nonempty=0 immediately, asynchronously.
